// File: rtl/reg_bus_arbiter_pkg.sv
// Shared constants for the board write-bus arbiter: FSM encoding,
// source slot assignments and main-space offsets of the diagnostic counters.
package reg_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLOCK = 2'd2
    } arb_state_e;

    localparam int SRC_FW  = 0;
    localparam int SRC_BW  = 1;
    localparam int SRC_ETH = 2;

    localparam logic [15:0] REG_DROP_COUNT  = 16'h00A0;
    localparam logic [15:0] REG_ABORT_COUNT = 16'h00A1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational one-hot winner: first requester at or after ptr, wrapping.
// With ptr tied to zero this is plain lowest-index-wins priority.
module arb_priority_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// NUM_SRC-way board write-bus arbiter with atomic block writes and timeout.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int BLK_TIMEOUT = 1023
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC-1:0]        src_reg_wen,
    input  logic [NUM_SRC-1:0]        src_blk_wen,
    input  logic [NUM_SRC-1:0]        src_blk_wstart,
    input  logic [NUM_SRC*ADDR_W-1:0] src_waddr,
    input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
    output logic [NUM_SRC-1:0]        src_gnt,
    output logic                      reg_wen,
    output logic                      blk_wen,
    output logic                      blk_wstart,
    output logic [ADDR_W-1:0]         reg_waddr,
    output logic [DATA_W-1:0]         reg_wdata,
    output logic                      bus_busy,
    output logic                      blk_abort,
    output logic [7:0]                drop_count,
    output logic [7:0]                abort_count
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TW = (BLK_TIMEOUT > 1) ? $clog2(BLK_TIMEOUT + 1) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_SRC-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       ptr_q;
    logic                reg_wen_q, reg_wen_d;
    logic                blk_wen_q, blk_wen_d;
    logic                blk_wstart_q, blk_wstart_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                abort_q, abort_d;
    logic [7:0]          drop_q, drop_d;
    logic [7:0]          abc_q, abc_d;

    logic [NUM_SRC-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic [NUM_SRC-1:0]  strobe, own_mask;
    logic                own_req, own_rwen, own_bwen, own_wstart;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_data;
    logic                timeout, accept, fwd, drop, start_grant;

    arb_priority_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
        .req     (src_req),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    assign own_req    = src_req[idx_q];
    assign own_rwen   = src_reg_wen[idx_q];
    assign own_bwen   = src_blk_wen[idx_q];
    assign own_wstart = src_blk_wstart[idx_q];
    assign own_addr   = src_waddr[int'(idx_q)*ADDR_W +: ADDR_W];
    assign own_data   = src_wdata[int'(idx_q)*DATA_W +: DATA_W];

    // The timeout cycle belongs to nobody: its strobes count as drops.
    assign strobe   = src_reg_wen | src_blk_wen | src_blk_wstart;
    assign timeout  = (state_q == BLOCK) && (timer_q == TW'(BLK_TIMEOUT - 1));
    assign accept   = (state_q != IDLE) && !timeout;
    assign own_mask = accept ? gnt_q : '0;
    assign fwd      = |(strobe & own_mask);
    assign drop     = |(strobe & ~own_mask);

    // A grant that was just released must stay low one cycle first.
    assign start_grant = (state_q == IDLE) && (gnt_q == '0) && (|src_req);

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        reg_wen_d    = accept & own_rwen;
        blk_wen_d    = accept & own_bwen;
        blk_wstart_d = accept & own_wstart;
        waddr_d      = fwd ? own_addr : waddr_q;
        wdata_d      = fwd ? own_data : wdata_q;
        abort_d      = 1'b0;
        drop_d       = drop ? sat_inc(drop_q) : drop_q;
        abc_d        = abc_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (start_grant) begin
                    state_d = GRANT;
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                end
            end
            GRANT: begin
                if (own_wstart) begin
                    state_d = BLOCK;
                    timer_d = '0;
                end else if (!own_req) begin
                    state_d = IDLE;
                    if (!fwd) gnt_d = '0;
                end
            end
            BLOCK: begin
                if (timeout) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    abort_d = 1'b1;
                    abc_d   = sat_inc(abc_q);
                end else if (own_bwen) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            reg_wen_q    <= 1'b0;
            blk_wen_q    <= 1'b0;
            blk_wstart_q <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            abort_q      <= 1'b0;
            drop_q       <= '0;
            abc_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            reg_wen_q    <= reg_wen_d;
            blk_wen_q    <= blk_wen_d;
            blk_wstart_q <= blk_wstart_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            abort_q      <= abort_d;
            drop_q       <= drop_d;
            abc_q        <= abc_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (start_grant)
            ptr_d = (pick_idx == IW'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    assign ptr_q = '0;
`endif

    assign src_gnt     = gnt_q;
    assign reg_wen     = reg_wen_q;
    assign blk_wen     = blk_wen_q;
    assign blk_wstart  = blk_wstart_q;
    assign reg_waddr   = waddr_q;
    assign reg_wdata   = wdata_q;
    assign bus_busy    = (state_q != IDLE);
    assign blk_abort   = abort_q;
    assign drop_count  = drop_q;
    assign abort_count = abc_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus random traffic
// checked against a transaction-level ownership model.
module tb_reg_bus_arbiter;

    localparam int N      = 3;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int BLK_TO = 15;

    logic          sysclk = 1'b0;
    logic          reset;
    logic [N-1:0]  src_req, src_reg_wen, src_blk_wen, src_blk_wstart;
    logic [N*AW-1:0] src_waddr;
    logic [N*DW-1:0] src_wdata;
    logic [N-1:0]  src_gnt;
    logic          reg_wen, blk_wen, blk_wstart, bus_busy, blk_abort;
    logic [AW-1:0] reg_waddr;
    logic [DW-1:0] reg_wdata;
    logic [7:0]    drop_count, abort_count;

    int checks = 0;
    int errors = 0;

    reg_bus_arbiter #(
        .NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW), .BLK_TIMEOUT(BLK_TO)
    ) dut (
        .sysclk(sysclk), .reset(reset),
        .src_req(src_req), .src_reg_wen(src_reg_wen),
        .src_blk_wen(src_blk_wen), .src_blk_wstart(src_blk_wstart),
        .src_waddr(src_waddr), .src_wdata(src_wdata),
        .src_gnt(src_gnt), .reg_wen(reg_wen), .blk_wen(blk_wen),
        .blk_wstart(blk_wstart), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .bus_busy(bus_busy),
        .blk_abort(blk_abort), .drop_count(drop_count),
        .abort_count(abort_count)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: who owns the bus, for how long, and what it saw.
    int            m_phase = 0;   // 0 free, 1 owned, 2 owned inside a block
    int            m_owner = 0;
    int            m_age   = 0;
    int            m_ptr   = 0;
    logic [N-1:0]  e_gnt   = '0;
    logic          e_rw = 0, e_bw = 0, e_bs = 0, e_abort = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    int            e_drop = 0, e_abc = 0;

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (src_req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] stb;
        bit tmo, acc, fwd, dropped;
        int w;
        stb = src_reg_wen | src_blk_wen | src_blk_wstart;
        if (reset) begin
            m_phase = 0; m_owner = 0; m_age = 0; m_ptr = 0;
            e_gnt = '0; e_rw = 0; e_bw = 0; e_bs = 0; e_abort = 0;
            e_addr = '0; e_data = '0; e_drop = 0; e_abc = 0;
            return;
        end
        tmo = (m_phase == 2) && (m_age + 1 == BLK_TO);
        acc = (m_phase != 0) && !tmo;
        fwd = acc && stb[m_owner];
        dropped = 0;
        for (int i = 0; i < N; i++)
            if (stb[i] && !(acc && i == m_owner)) dropped = 1;
        if (dropped && e_drop < 255) e_drop++;
        e_rw = acc && src_reg_wen[m_owner];
        e_bw = acc && src_blk_wen[m_owner];
        e_bs = acc && src_blk_wstart[m_owner];
        if (fwd) begin
            e_addr = src_waddr[m_owner*AW +: AW];
            e_data = src_wdata[m_owner*DW +: DW];
        end
        e_abort = 0;
        if (m_phase == 0) begin
            if (e_gnt != 0) e_gnt = '0;
            else begin
                w = model_pick();
                if (w >= 0) begin
                    m_owner = w;
                    e_gnt = N'(1 << w);
                    m_phase = 1;
`ifdef ARB_ROUND_ROBIN_EN
                    m_ptr = (w + 1) % N;
`endif
                end
            end
        end else if (m_phase == 1) begin
            if (src_blk_wstart[m_owner]) begin
                m_phase = 2; m_age = 0;
            end else if (!src_req[m_owner]) begin
                m_phase = 0;
                if (!fwd) e_gnt = '0;
            end
        end else begin
            if (tmo) begin
                m_phase = 0; e_gnt = '0; e_abort = 1;
                if (e_abc < 255) e_abc++;
            end else if (src_blk_wen[m_owner]) m_phase = 0;
            else m_age++;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic clr();
        src_req = '0; src_reg_wen = '0; src_blk_wen = '0;
        src_blk_wstart = '0; src_waddr = '0; src_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr();
        cyc();
        cyc();
        checks++;
        if ({src_gnt, reg_wen, blk_wen, blk_wstart, bus_busy, blk_abort} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {src_gnt, reg_wen, blk_wen, blk_wstart, bus_busy, blk_abort});
        end
        checks++;
        if ({reg_waddr, reg_wdata, drop_count, abort_count} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0",
                     {reg_waddr, reg_wdata, drop_count, abort_count});
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_fixed_priority();
        src_req = 3'b110;
        cyc();
        checks++;
        if (src_gnt !== 3'b010) begin
            errors++; $display("FAIL prio_gnt: got %b required 010", src_gnt);
        end
        src_reg_wen[1] = 1'b1;
        src_waddr[AW +: AW] = 16'h0012;
        src_wdata[DW +: DW] = 32'hDEADBEEF;
        cyc();
        checks++;
        if ({reg_wen, reg_waddr, reg_wdata, drop_count} !== {1'b1, 16'h0012, 32'hDEADBEEF, 8'd0}) begin
            errors++;
            $display("FAIL prio_write: got %b %h %h %0d required 1 0012 deadbeef 0",
                     reg_wen, reg_waddr, reg_wdata, drop_count);
        end
        clr();
        cyc();
        checks++;
        if (src_gnt !== 3'b000 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL prio_release: got gnt %b wen %b required 000 0", src_gnt, reg_wen);
        end
        cyc();
    endtask

    task automatic test_contention();
        src_req = 3'b001;
        cyc();
        checks++;
        if (src_gnt !== 3'b001) begin
            errors++; $display("FAIL cont_gnt: got %b required 001", src_gnt);
        end
        for (int p = 0; p < 3; p++) begin
            src_reg_wen[2] = 1'b1;
            src_waddr[2*AW +: AW] = AW'($urandom);
            cyc();
            src_reg_wen[2] = 1'b0;
            cyc();
            checks++;
            if (reg_wen !== 1'b0 || blk_wen !== 1'b0 || blk_wstart !== 1'b0) begin
                errors++; $display("FAIL cont_leak: got strobes %b%b%b required 000", reg_wen, blk_wen, blk_wstart);
            end
        end
        checks++;
        if (drop_count !== 8'd3) begin
            errors++; $display("FAIL cont_drop: got %0d required 3", drop_count);
        end
        clr();
        cyc();
        cyc();
    endtask

    task automatic test_block();
        src_req = 3'b010;
        cyc();
        src_blk_wstart[1] = 1'b1;
        cyc();
        checks++;
        if (blk_wstart !== 1'b1 || bus_busy !== 1'b1) begin
            errors++; $display("FAIL blk_start: got %b busy %b required 1 1", blk_wstart, bus_busy);
        end
        src_blk_wstart = '0;
        src_req = '0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            checks++;
            if (src_gnt !== 3'b010) begin
                errors++; $display("FAIL blk_hold: cycle %0d got %b required 010", k, src_gnt);
            end
        end
        src_blk_wen[1] = 1'b1;
        src_req = 3'b001;
        cyc();
        checks++;
        if ({blk_wen, src_gnt, bus_busy} !== {1'b1, 3'b010, 1'b0}) begin
            errors++; $display("FAIL blk_end: got wen %b gnt %b busy %b required 1 010 0", blk_wen, src_gnt, bus_busy);
        end
        src_blk_wen = '0;
        cyc();
        checks++;
        if (src_gnt !== 3'b000) begin
            errors++; $display("FAIL blk_gap: got %b required 000", src_gnt);
        end
        cyc();
        checks++;
        if (src_gnt !== 3'b001) begin
            errors++; $display("FAIL blk_next: got %b required 001", src_gnt);
        end
        clr();
        cyc();
        cyc();
    endtask

    task automatic test_timeout();
        src_req = 3'b100;
        cyc();
        src_blk_wstart[2] = 1'b1;
        cyc();
        src_blk_wstart = '0;
        for (int k = 1; k < BLK_TO; k++) begin
            cyc();
            checks++;
            if (blk_abort !== 1'b0) begin
                errors++; $display("FAIL to_early: cycle %0d got abort 1 required 0", k);
            end
        end
        src_reg_wen[2] = 1'b1;
        cyc();
        checks++;
        if ({blk_abort, abort_count, src_gnt, reg_wen, drop_count} !== {1'b1, 8'd1, 3'b000, 1'b0, 8'd4}) begin
            errors++;
            $display("FAIL to_abort: got abort %b cnt %0d gnt %b wen %b drop %0d required 1 1 000 0 4",
                     blk_abort, abort_count, src_gnt, reg_wen, drop_count);
        end
        src_reg_wen = '0;
        cyc();
        checks++;
        if (blk_abort !== 1'b0) begin
            errors++; $display("FAIL to_pulse: got %b required 0", blk_abort);
        end
        clr();
        cyc();
    endtask

    task automatic test_reset_mid_block();
        src_req = 3'b001;
        cyc();
        src_blk_wstart[0] = 1'b1;
        cyc();
        src_blk_wstart = '0;
        cyc();
        reset = 1'b1;
        clr();
        cyc();
        checks++;
        if ({src_gnt, reg_wen, blk_wen, blk_wstart, bus_busy, blk_abort,
             reg_waddr, reg_wdata, drop_count, abort_count} !== '0) begin
            errors++;
            $display("FAIL rst_block: got gnt %b busy %b drop %0d abort %0d required all 0",
                     src_gnt, bus_busy, drop_count, abort_count);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_arbitration_order();
        int exp_order[4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        src_req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            int idx, waited;
            waited = 0;
            while (src_gnt == '0 && waited < 8) begin
                cyc();
                waited++;
            end
            idx = -1;
            for (int i = 0; i < N; i++) if (src_gnt[i]) idx = i;
            checks++;
            if (idx != exp_order[n]) begin
                errors++; $display("FAIL order_%0d: got %0d required %0d", n, idx, exp_order[n]);
            end
            if (idx < 0) break;
            src_reg_wen[idx] = 1'b1;
            cyc();
            src_reg_wen = '0;
            src_req[idx] = 1'b0;
            cyc();
            src_req[idx] = 1'b1;
        end
        clr();
        cyc();
        cyc();
    endtask

    task automatic test_random();
        logic [71:0] got, want;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) src_req[i] = ~src_req[i];
                src_reg_wen[i]    = ($urandom_range(5) == 0);
                src_blk_wen[i]    = ($urandom_range(11) == 0);
                src_blk_wstart[i] = ($urandom_range(9) == 0);
            end
            src_waddr = {$urandom, $urandom};
            src_wdata = {$urandom, $urandom, $urandom};
            cyc();
            want = {e_gnt, e_rw, e_bw, e_bs, e_addr, e_data, (m_phase != 0),
                    e_abort, 8'(e_drop), 8'(e_abc)};
            got  = {src_gnt, reg_wen, blk_wen, blk_wstart, reg_waddr, reg_wdata,
                    bus_busy, blk_abort, drop_count, abort_count};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL rand_%0d: got %h required %h", c, got, want);
            end
        end
        reset = 1'b0;
        clr();
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        clr();
        test_reset();
        test_fixed_priority();
        test_contention();
        test_block();
        test_timeout();
        test_reset_mid_block();
        test_arbitration_order();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
